// File: rtl/instr_encoder_if.sv
// Descriptor input, encoded-word output and status bundle of instr_encoder.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [12:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        err_pulse;
  logic [15:0] emit_count;
  logic [7:0]  err_count;

  // Producer/consumer side (program loader, testbench).
  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, err_pulse, emit_count, err_count
  );

  // Encoder side.
  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, err_pulse, emit_count, err_count
  );
endinterface

// File: rtl/instr_encoder.sv
// Streaming RV64I-subset instruction encoder with a 2-entry output queue.
module instr_encoder (
  input  logic          clk,
  input  logic          rst_n,
  instr_encoder_if.slave bus
);

  logic [1:0]  count;
  logic [31:0] head;
  logic [31:0] tail;
  logic [2:0]  f3;
  logic [31:0] word;
  logic        legal;
  logic        fits12;
  logic        fits_sh;
  logic        acc;
  logic        push;
  logic        pop;
  logic [15:0] emit_q;
  logic [7:0]  err_q;
  logic        pulse_q;

  assign fits12  = (bus.in_imm[12] == bus.in_imm[11]);
  assign fits_sh = (bus.in_imm[12:6] == 7'd0);

  assign bus.in_ready   = rst_n && ((count != 2'd2) || bus.out_ready);
  assign bus.out_valid  = (count != 2'd0);
  assign bus.out_instr  = head;
  assign bus.err_pulse  = pulse_q;
  assign bus.emit_count = emit_q;
  assign bus.err_count  = err_q;

  assign acc  = bus.in_valid && bus.in_ready;
  assign push = acc && legal;
  assign pop  = bus.out_valid && bus.out_ready;

  // funct3 selection shared by R-type and immediate forms.
  always_comb begin
    f3 = 3'b000;
    case (bus.in_op)
      4'd2, 4'd8:   f3 = 3'b111;
      4'd3, 4'd9:   f3 = 3'b110;
      4'd4, 4'd10:  f3 = 3'b100;
      4'd5, 4'd11:  f3 = 3'b001;
      4'd6, 4'd12:  f3 = 3'b101;
      4'd13, 4'd14: f3 = 3'b011;
      default:      f3 = 3'b000;
    endcase
  end

  // Instruction word assembly and immediate legality check.
  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (bus.in_op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
        word = {(bus.in_op == 4'd1) ? 7'b0100000 : 7'b0000000,
                bus.in_rs2, bus.in_rs1, f3, bus.in_rd, 7'b0110011};
      end
      4'd7, 4'd8, 4'd9, 4'd10: begin
        word  = {bus.in_imm[11:0], bus.in_rs1, f3, bus.in_rd, 7'b0010011};
        legal = fits12;
      end
      4'd11, 4'd12: begin
        word  = {6'b000000, bus.in_imm[5:0], bus.in_rs1, f3, bus.in_rd, 7'b0010011};
        legal = fits_sh;
      end
      4'd13: begin
        word  = {bus.in_imm[11:0], bus.in_rs1, f3, bus.in_rd, 7'b0000011};
        legal = fits12;
      end
      4'd14: begin
        word  = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, f3,
                 bus.in_imm[4:0], 7'b0100011};
        legal = fits12;
      end
      default: begin
        word  = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, 3'b000,
                 bus.in_imm[4:1], bus.in_imm[11], 7'b1100011};
        legal = ~bus.in_imm[0];
      end
    endcase
  end

  // Queue storage: head is the registered output, tail holds the second word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= word;
          else               tail <= word;
          count <= count + 2'd1;
        end
        2'b01: begin
          // Only shift when a second word exists so an emptied head keeps its value.
          if (count == 2'd2) head <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            head <= tail;
            tail <= word;
          end else begin
            head <= word;
          end
        end
        default: ;
      endcase
    end
  end

  // Handoff counter, error counter and one-cycle error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      emit_q  <= '0;
      err_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      if (pop) emit_q <= emit_q + 16'd1;
      pulse_q <= acc && !legal;
      if (acc && !legal && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: vectors, corner sequences, random traffic.
module tb_instr_encoder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_encoder_if bus ();

  instr_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: queue of expected words plus expected status.
  logic [31:0] mq[$];
  int          m_emit = 0;
  int          m_err = 0;
  bit          m_pulse = 0;
  bit          last_acc = 0;
  int          cur_op, cur_rd, cur_rs1, cur_rs2, cur_imm;

  typedef struct {
    int          op;
    int          rd;
    int          rs1;
    int          rs2;
    int          imm;
    logic [31:0] w;
  } vec_t;

  vec_t tv[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_legal(input int op, input int imm);
    if ((op >= 7 && op <= 10) || op == 13 || op == 14) return (imm >= -2048) && (imm <= 2047);
    if (op == 11 || op == 12) return (imm >= 0) && (imm <= 63);
    if (op == 15) return (imm % 2) == 0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] ref_word(input int op, input int rd, input int rs1,
                                           input int rs2, input int imm);
    int unsigned f3tab[16];
    int unsigned u;
    int unsigned w;
    f3tab = '{0, 0, 7, 6, 4, 1, 5, 0, 7, 6, 4, 1, 5, 3, 3, 0};
    u = int'(imm) & 32'h1FFF;
    w = 0;
    if (op <= 6)
      w = ((op == 1) ? 32 : 0) * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15)
          + f3tab[op] * (1 << 12) + rd * (1 << 7) + 51;
    else if (op <= 10 || op == 13)
      w = (u % 4096) * (1 << 20) + rs1 * (1 << 15) + f3tab[op] * (1 << 12)
          + rd * (1 << 7) + ((op == 13) ? 3 : 19);
    else if (op <= 12)
      w = (u % 64) * (1 << 20) + rs1 * (1 << 15) + f3tab[op] * (1 << 12) + rd * (1 << 7) + 19;
    else if (op == 14)
      w = ((u / 32) % 128) * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15) + 3 * (1 << 12)
          + (u % 32) * (1 << 7) + 35;
    else
      w = ((u / 4096) % 2) * (1 << 31) + ((u / 32) % 64) * (1 << 25) + rs2 * (1 << 20)
          + rs1 * (1 << 15) + ((u / 2) % 16) * (1 << 8) + ((u / 2048) % 2) * (1 << 7) + 99;
    return w;
  endfunction

  task automatic drive(input int op, input int rd, input int rs1, input int rs2, input int imm);
    cur_op = op; cur_rd = rd; cur_rs1 = rs1; cur_rs2 = rs2; cur_imm = imm;
    bus.in_op    = 4'(op);
    bus.in_rd    = 5'(rd);
    bus.in_rs1   = 5'(rs1);
    bus.in_rs2   = 5'(rs2);
    bus.in_imm   = 13'(imm);
    bus.in_valid = 1'b1;
  endtask

  // One clock: check status against the model at negedge, advance model, return at posedge+1.
  task automatic cyc();
    bit exp_rdy, acc, pop;
    @(negedge clk);
    exp_rdy = rst_n && ((mq.size() < 2) || bus.out_ready);
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
    chk("err_pulse", 32'(bus.err_pulse), 32'(m_pulse));
    chk("emit_count", 32'(bus.emit_count), m_emit);
    chk("err_count", 32'(bus.err_count), m_err);
    acc = bus.in_valid && exp_rdy;
    pop = (mq.size() != 0) && bus.out_ready;
    if (pop) begin
      chk("out_instr", bus.out_instr, mq[0]);
      void'(mq.pop_front());
      m_emit = (m_emit + 1) % 65536;
    end
    m_pulse = 0;
    if (acc) begin
      if (ref_legal(cur_op, cur_imm))
        mq.push_back(ref_word(cur_op, cur_rd, cur_rs1, cur_rs2, cur_imm));
      else begin
        m_pulse = 1;
        if (m_err < 255) m_err++;
      end
    end
    if (!rst_n) begin
      mq.delete();
      m_emit = 0;
      m_err = 0;
      m_pulse = 0;
    end
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int op, input int rd, input int rs1, input int rs2, input int imm);
    bit done;
    done = 0;
    drive(op, rd, rs1, rs2, imm);
    for (int unsigned k = 0; k < 20 && !done; k++) begin
      cyc();
      done = last_acc;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout: got not-accepted expected accepted op %0d", op);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    tv[0] = '{0, 3, 1, 2, 0, 32'h002081B3};
    tv[1] = '{1, 4, 5, 6, 0, 32'h40628233};
    tv[2] = '{7, 1, 0, 0, 5, 32'h00500093};
    tv[3] = '{13, 4, 0, 0, 0, 32'h00003203};
    tv[4] = '{14, 0, 0, 3, 0, 32'h00303023};
    tv[5] = '{15, 0, 1, 2, 16, 32'h00208863};
    tv[6] = '{7, 1, 1, 0, -2048, 32'h80008093};
    tv[7] = '{15, 0, 0, 0, -4096, 32'h80000063};
    tv[8] = '{11, 2, 2, 0, 63, 32'h03F11113};

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    drive(0, 0, 0, 0, 0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    cyc();
    chk("reset_out_instr", bus.out_instr, 32'h0);
    chk("reset_out_valid", 32'(bus.out_valid), 32'h0);
    rst_n = 1'b1;

    // Encoding vectors and immediate extremes.
    bus.out_ready = 1'b1;
    for (int unsigned i = 0; i < 9; i++) begin
      send(tv[i].op, tv[i].rd, tv[i].rs1, tv[i].rs2, tv[i].imm);
      chk("vec_valid", 32'(bus.out_valid), 32'h1);
      chk($sformatf("vec%0d_word", i), bus.out_instr, tv[i].w);
      if (i == 6) chk("emit_after_six", 32'(bus.emit_count), 32'd6);
    end
    cyc();
    chk("emit_after_vectors", 32'(bus.emit_count), 32'd9);

    // Back-pressure: third descriptor waits, head stays on the first word.
    do_reset();
    bus.out_ready = 1'b0;
    send(0, 10, 1, 2, 0);
    send(2, 11, 3, 4, 0);
    drive(4, 12, 5, 6, 0);
    chk("bp_in_ready_low", 32'(bus.in_ready), 32'h0);
    cyc();
    chk("bp_not_accepted", 32'(last_acc), 32'h0);
    chk("bp_head_stable", bus.out_instr, ref_word(0, 10, 1, 2, 0));
    bus.out_ready = 1'b1;
    cyc();
    chk("bp_third_accepted", 32'(last_acc), 32'h1);
    bus.in_valid = 1'b0;
    chk("bp_second_word", bus.out_instr, ref_word(2, 11, 3, 4, 0));
    cyc();
    chk("bp_third_word", bus.out_instr, ref_word(4, 12, 5, 6, 0));
    cyc();
    chk("bp_drained", 32'(bus.out_valid), 32'h0);
    chk("bp_emit", 32'(bus.emit_count), 32'd3);

    // Illegal descriptors are consumed without enqueueing.
    do_reset();
    send(7, 1, 1, 0, 2048);
    chk("ill_pulse0", 32'(bus.err_pulse), 32'h1);
    chk("ill_noword0", 32'(bus.out_valid), 32'h0);
    send(11, 1, 1, 0, 64);
    chk("ill_pulse1", 32'(bus.err_pulse), 32'h1);
    send(15, 0, 1, 2, 3);
    chk("ill_pulse2", 32'(bus.err_pulse), 32'h1);
    chk("ill_count", 32'(bus.err_count), 32'd3);
    send(0, 5, 6, 7, 0);
    chk("ill_pulse_clear", 32'(bus.err_pulse), 32'h0);
    chk("ill_then_legal_valid", 32'(bus.out_valid), 32'h1);
    chk("ill_then_legal_word", bus.out_instr, 32'h007302B3);
    cyc();

    // Reset mid-stream discards queued words.
    bus.out_ready = 1'b0;
    send(0, 1, 2, 3, 0);
    send(1, 4, 5, 6, 0);
    do_reset();
    chk("midrst_valid", 32'(bus.out_valid), 32'h0);
    chk("midrst_emit", 32'(bus.emit_count), 32'h0);
    chk("midrst_err", 32'(bus.err_count), 32'h0);
    bus.out_ready = 1'b1;
    send(3, 7, 8, 9, 0);
    chk("midrst_first_out", bus.out_instr, ref_word(3, 7, 8, 9, 0));
    cyc();

    // Random traffic against the model.
    do_reset();
    for (int unsigned i = 0; i < 3000; i++) begin
      int imm;
      case ($urandom_range(0, 3))
        0: imm = int'($urandom_range(0, 8191)) - 4096;
        1: imm = int'($urandom_range(0, 4095)) - 2048;
        2: imm = int'($urandom_range(0, 70));
        default: imm = int'($urandom_range(0, 40)) - 20;
      endcase
      drive(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), imm);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    cyc();
    cyc();

    // emit_count wrap after 65536 handoffs.
    do_reset();
    bus.out_ready = 1'b1;
    drive(0, 1, 2, 3, 0);
    for (int unsigned i = 0; i < 65536; i++) cyc();
    bus.in_valid = 1'b0;
    cyc();
    chk("emit_wrap", 32'(bus.emit_count), 32'h0);

    // err_count saturation.
    drive(7, 1, 1, 0, 3000);
    for (int unsigned i = 0; i < 300; i++) cyc();
    bus.in_valid = 1'b0;
    cyc();
    chk("err_saturate", 32'(bus.err_count), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
